// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Drives the Send/Busy handshake for the granted requester, with a start timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_send,
  output logic [7:0]           tx_din,
  input  logic                 tx_busy,
  output logic                 timeout_err
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt, gidx, gidx_nxt, ptr_after_g;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
  logic               tx_send_nxt, timeout_err_nxt;
  logic [7:0]         tx_din_nxt;
  logic [7:0]         data_arr [NUM_REQ];
  logic               found;
  logic [IW-1:0]      sel, idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[8*gi +: 8];
  end

  // First requester found when scanning from rr_ptr upward, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    ptr_after_g = IW'((32'(gidx) + 32'd1) % NUM_REQ);
  end

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    gidx_nxt        = gidx;
    cnt_nxt         = cnt;
    grant_nxt       = grant;
    ack_nxt         = '0;
    tx_send_nxt     = tx_send;
    tx_din_nxt      = tx_din;
    timeout_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && found) begin
          state_nxt   = START;
          gidx_nxt    = sel;
          grant_nxt   = NUM_REQ'(1) << sel;
          tx_din_nxt  = data_arr[sel];
          tx_send_nxt = 1'b1;
          cnt_nxt     = '0;
        end
      end
      START: begin
        // Busy wins over the timeout when both occur on the final count.
        if (tx_busy) begin
          state_nxt   = BUSY;
          tx_send_nxt = 1'b0;
          ack_nxt     = grant;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt       = IDLE;
          tx_send_nxt     = 1'b0;
          timeout_err_nxt = 1'b1;
          grant_nxt       = '0;
          cnt_nxt         = '0;
          rr_ptr_nxt      = ptr_after_g;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      BUSY: begin
        if (!tx_busy) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          cnt_nxt    = '0;
          rr_ptr_nxt = ptr_after_g;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gidx        <= '0;
      cnt         <= '0;
      grant       <= '0;
      ack         <= '0;
      tx_send     <= 1'b0;
      tx_din      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      gidx        <= gidx_nxt;
      cnt         <= cnt_nxt;
      grant       <= grant_nxt;
      ack         <= ack_nxt;
      tx_send     <= tx_send_nxt;
      tx_din      <= tx_din_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand-written corner sequences and
// randomized transfers checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_busy = 1'b0;
  logic [N-1:0]   ack, grant;
  logic           tx_send, timeout_err;
  logic [7:0]     tx_din;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .grant(grant), .tx_send(tx_send), .tx_din(tx_din), .tx_busy(tx_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    int             dly;
    int             hold;
    int             g;
    logic [7:0]     d;
    bit             mut;
    logic [7:0]     mval;
  } vec_t;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One transfer started from IDLE: requester g must be granted with byte d.
  // The transmitter model raises busy dly cycles after send and holds it hold cycles,
  // or never raises it when to=1.
  task automatic run_xfer(input int g, input logic [7:0] d, input int dly, input int hold,
                          input bit to, input bit mut, input logic [7:0] mval);
    int         w;
    int         n;
    bit         bad;
    logic [N-1:0] oh;
    oh = N'(1) << g;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!tx_send && w < 40);
    chk("send_latency", w, 1);
    chk("grant", grant, oh);
    chk("tx_din", tx_din, d);
    chk("ack_at_send", ack, 0);
    chk("terr_at_send", timeout_err, 0);
    if (mut) req_data[8*g +: 8] = mval;
    bad = 1'b0;
    if (to) begin
      n = 1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!tx_send) break;
        n++;
        bad |= (ack != 0) || (tx_din !== d);
      end
      chk("to_send_cycles", n, TO);
      chk("to_err_pulse", timeout_err, 1);
      chk("to_no_ack", {bad, ack != 0}, 0);
      chk("to_grant_clear", grant, 0);
    end else begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        bad |= !tx_send || (tx_din !== d) || (ack != 0) || (grant != oh);
      end
      chk("start_hold", bad, 0);
      tx_busy = 1'b1;
      @(negedge clk);
      chk("ack", ack, oh);
      chk("send_drop", tx_send, 0);
      @(negedge clk);
      chk("ack_one_cycle", ack, 0);
      bad = (grant != oh);
      for (int k = 2; k < hold; k++) begin
        @(negedge clk);
        bad |= (grant != oh) || (ack != 0) || tx_send;
      end
      chk("busy_hold", bad, 0);
      tx_busy = 1'b0;
      @(negedge clk);
      chk("release_grant", grant, 0);
      chk("idle_gap_send", tx_send, 0);
    end
  endtask

  vec_t          vecs[8];
  bit [N-1:0]    pend;
  logic [7:0]    md[N];
  int            mptr, g, w;
  bit            to, bad;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, grant=%0h tx_send=%0b", grant, tx_send);
    $fatal(1);
  end

  initial begin
    // Round robin with all requesting, then a late narrowing, single requester,
    // and a data change after grant.
    vecs[0] = '{4'b1111, 32'hf00f00ff, 2, 3, 0, 8'hff, 1'b0, 8'h00};
    vecs[1] = '{4'b1111, 32'hf00f00ff, 1, 2, 1, 8'h00, 1'b0, 8'h00};
    vecs[2] = '{4'b1111, 32'hf00f00ff, 0, 4, 2, 8'h0f, 1'b0, 8'h00};
    vecs[3] = '{4'b1111, 32'hf00f00ff, 5, 2, 3, 8'hf0, 1'b0, 8'h00};
    vecs[4] = '{4'b1111, 32'hf00f00ff, 3, 3, 0, 8'hff, 1'b0, 8'h00};
    vecs[5] = '{4'b1001, 32'hf00f00ff, 1, 2, 3, 8'hf0, 1'b0, 8'h00};
    vecs[6] = '{4'b0100, 32'h00370000, 3, 20, 2, 8'h37, 1'b0, 8'h00};
    vecs[7] = '{4'b0001, 32'h000000aa, 4, 3, 0, 8'haa, 1'b1, 8'h55};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_din", tx_din, 0);
    chk("rst_terr", timeout_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req      = vecs[i].req;
      req_data = vecs[i].data;
      run_xfer(vecs[i].g, vecs[i].d, vecs[i].dly, vecs[i].hold, 1'b0, vecs[i].mut, vecs[i].mval);
    end

    // Transmitter busy from elsewhere: nothing may be sent until it frees up.
    tx_busy  = 1'b1;
    req      = 4'b0001;
    req_data = 32'h0000005a;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bad |= tx_send || (grant != 0);
    end
    chk("busy_entry_wait", bad, 0);
    tx_busy = 1'b0;
    run_xfer(0, 8'h5a, 1, 2, 1'b0, 1'b0, 8'h00);

    // Start timeout, then show the pointer moved past the aborted requester.
    req      = 4'b0010;
    req_data = 32'h00007700;
    run_xfer(1, 8'h77, 0, 2, 1'b1, 1'b0, 8'h00);
    req      = 4'b0110;
    req_data = 32'h00886600;
    run_xfer(2, 8'h88, 1, 2, 1'b0, 1'b0, 8'h00);

    // Reset during BUSY with the pointer at 1; afterwards requester 0 must win.
    req      = 4'b0001;
    req_data = 32'h000000c1;
    run_xfer(0, 8'hc1, 1, 2, 1'b0, 1'b0, 8'h00);
    req      = 4'b0010;
    req_data = 32'h0000d200;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!tx_send && w < 40);
    chk("pre_rst_grant", grant, 4'b0010);
    tx_busy = 1'b1;
    @(negedge clk);
    chk("pre_rst_ack", ack, 4'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_send", tx_send, 0);
    chk("midrst_din", tx_din, 0);
    chk("midrst_terr", timeout_err, 0);
    tx_busy  = 1'b0;
    req      = 4'b0011;
    req_data = 32'h0000bbcc;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(0, 8'hcc, 2, 2, 1'b0, 1'b0, 8'h00);

    // Randomized traffic against a request-set / pointer model.
    mptr = 1;
    pend = '0;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          md[i]   = 8'($urandom);
        end
      end
      if (pend == 0) begin
        pend[r % N] = 1'b1;
        md[r % N]   = 8'($urandom);
      end
      req      = pend;
      req_data = {md[3], md[2], md[1], md[0]};
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
      to = ($urandom_range(7, 0) == 0);
      run_xfer(g, md[g], int'($urandom_range(12, 0)), int'($urandom_range(6, 2)), to, 1'b0, 8'h00);
      mptr = (g + 1) % N;
      if (!to) pend[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte-producing requesters using round-robin arbitration. The block sequences the transmitter's Send/Busy handshake on behalf of the granted requester and returns a one-cycle ack when that requester's byte is accepted. It includes a start-timeout, so a transmitter that never raises Busy cannot hang the arbiter. It sits between the application clients and the single tx instance in the UART top level.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
TIMEOUT_CYCLES, 16, clocks to wait for tx_busy to rise after tx_send asserts before aborting.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  req[i]=1: requester i has a byte pending. Requester holds req and its data stable until ack[i].
req_data  input  8*NUM_REQ  byte for requester i at req_data[8*i+7:8*i].
ack  output  NUM_REQ  one-cycle pulse to requester i when its byte has been accepted by tx.
grant  output  NUM_REQ  one-hot; the currently owning requester; all zero when idle.
tx_send  output  1  Send request to the transmitter.
tx_din  output  8  byte to the transmitter; stable while tx_send=1.
tx_busy  input  1  transmitter Busy; high while serializing a byte.
timeout_err  output  1  one-cycle pulse when a start timeout aborts a grant.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grant=0; ack=0; tx_send=0; tx_din=8'h00; timeout_err=0; rr_ptr=0; timeout counter=0.
- rr_ptr: the index with highest priority. Search order is rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- States:
  - IDLE:
    - If tx_busy=0 and any req bit is set, select the first set bit in search order as index g.
    - Next cycle: grant[g]=1, tx_din=req_data[g] (registered), tx_send=1; go to START.
    - If tx_busy=1 (transmitter still busy from an external source), stay in IDLE.
  - START:
    - Hold tx_send and tx_din. Increment the counter each cycle.
    - If tx_busy=1: deassert tx_send, pulse ack[g] for exactly one cycle, go to BUSY.
    - If the counter reaches TIMEOUT_CYCLES-1 with tx_busy still 0: deassert tx_send, pulse timeout_err, clear grant, go to IDLE. No ack is issued, and rr_ptr is still advanced past g.
  - BUSY:
    - Wait for tx_busy=0. Then clear grant, set rr_ptr=(g+1) mod NUM_REQ, clear the counter, go to IDLE.
- Latency: req seen in IDLE with tx_busy=0 -> tx_send high on the next cycle. Back-to-back grants have at least one IDLE cycle between BUSY exit and the next tx_send.
- tx_din is captured at grant time. Changes to req_data after the grant are ignored for that transfer.
- Deasserting req[g] after grant, before ack: the transfer still completes and ack still pulses. Requesters must not do this; it is not an error condition.
- Multiple simultaneous requests: exactly one grant. Every persistently requesting client is served within NUM_REQ transfers (no starvation).
- grant is always one-hot or zero. ack is nonzero only in the cycle of the START->BUSY transition.
- Mid-operation reset: all outputs return to reset values immediately (asynchronously). The in-flight byte gets no ack.

Test Plan:
1. Single requester: NUM_REQ=4, req=4'b0100, req_data[23:16]=8'h37, tx model raises busy 3 clocks after send and holds it 20 clocks. Required: tx_din=8'h37; grant=4'b0100; ack=4'b0100 for one cycle; grant=0 after busy falls.
2. Round-robin: all req=4'b1111 held, data 8'hff/8'h00/8'h0f/8'hf0. Required: grant order 0,1,2,3,0 and tx_din order ff,00,0f,f0,ff. Then set req=4'b1001 immediately after the grant to 0. Required: next grant=3.
3. Timeout: tx_busy tied 0 with req=4'b0010. Required: tx_send high for exactly 16 cycles, timeout_err pulses once, no ack, rr_ptr=2.
4. Busy on entry: tx_busy=1 externally with req=4'b0001. Required: no tx_send until busy falls, then grant 0 on the next cycle.
5. Data stability: change req_data[7:0] from 8'haa to 8'h55 one cycle after grant[0]. Required: tx_din remains 8'haa through the transfer.
6. Reset mid-transfer: drop rst_n during BUSY. Required: all outputs zero the same cycle. After release with req=4'b0001, grant[0] is issued from rr_ptr=0.
